// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside ID: shadow scoreboard of in-flight rd writes,
// operand forwarding mux, load-use stall and a saturating stall-cycle counter.
module pipe_hazard_unit #(
  parameter int XLEN             = 32,
  parameter int FWD_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_WIDTH        = 32,
  localparam int SEL_W           = $clog2(FWD_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  input  logic                       rs1_re_i,
  input  logic                       rs2_re_i,
  input  logic [4:0]                 rs1_addr_i,
  input  logic [4:0]                 rs2_addr_i,
  input  logic                       rd_we_i,
  input  logic [4:0]                 rd_addr_i,
  input  logic                       is_load_i,
  input  logic                       flush_i,
  input  logic                       hold_i,
  input  logic [XLEN-1:0]            rs1_reg_data_i,
  input  logic [XLEN-1:0]            rs2_reg_data_i,
  input  logic [FWD_STAGES*XLEN-1:0] stage_data_i,
  output logic                       stall_o,
  output logic [SEL_W-1:0]           fwd_sel1_o,
  output logic [SEL_W-1:0]           fwd_sel2_o,
  output logic [XLEN-1:0]            rs1_data_o,
  output logic [XLEN-1:0]            rs2_data_o,
  output logic [CNT_WIDTH-1:0]       stall_cnt_o
);

  typedef struct packed {
    logic             haz;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  data;
  } lookup_t;

  // Index k-1 holds the instruction currently in stage k
  logic       sb_vld_q [FWD_STAGES];
  logic [4:0] sb_rd_q  [FWD_STAGES];
  logic       sb_ld_q  [FWD_STAGES];
  logic       sb_vld_d [FWD_STAGES];
  logic [4:0] sb_rd_d  [FWD_STAGES];
  logic       sb_ld_d  [FWD_STAGES];
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  lookup_t lk1, lk2;

  function automatic lookup_t lookup(input logic re, input logic [4:0] addr,
                                     input logic [XLEN-1:0] rf);
    lookup_t r;
    int      hit_k;
    r     = '0;
    hit_k = 0;
    if (re && addr != 5'd0) begin
      r.data = rf;
      // Scan oldest to youngest so the youngest match overwrites
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (sb_vld_q[k-1] && sb_rd_q[k-1] == addr) hit_k = k;
      end
      if (hit_k != 0) begin
        if (sb_ld_q[hit_k-1] && hit_k < LOAD_READY_STAGE) begin
          r.haz = 1'b1;
        end else begin
          r.sel  = SEL_W'(hit_k);
          r.data = stage_data_i[(hit_k-1)*XLEN +: XLEN];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    lk1 = lookup(rs1_re_i, rs1_addr_i, rs1_reg_data_i);
    lk2 = lookup(rs2_re_i, rs2_addr_i, rs2_reg_data_i);
  end

  assign stall_o     = (lk1.haz | lk2.haz) & id_valid_i & ~flush_i;
  assign fwd_sel1_o  = lk1.sel;
  assign fwd_sel2_o  = lk2.sel;
  assign rs1_data_o  = lk1.data;
  assign rs2_data_o  = lk2.data;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    for (int k = 0; k < FWD_STAGES; k++) begin
      sb_vld_d[k] = sb_vld_q[k];
      sb_rd_d[k]  = sb_rd_q[k];
      sb_ld_d[k]  = sb_ld_q[k];
    end
    stall_cnt_d = stall_cnt_q;
    if (!hold_i) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        sb_vld_d[k] = sb_vld_q[k-1];
        sb_rd_d[k]  = sb_rd_q[k-1];
        sb_ld_d[k]  = sb_ld_q[k-1];
      end
      // A flushed or stalled ID instruction enters EX as a bubble
      sb_vld_d[0] = ~(flush_i | stall_o) & id_valid_i & rd_we_i & (rd_addr_i != 5'd0);
      sb_rd_d[0]  = rd_addr_i;
      sb_ld_d[0]  = is_load_i;
      if (stall_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        sb_vld_q[k] <= 1'b0;
        sb_rd_q[k]  <= 5'd0;
        sb_ld_q[k]  <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        sb_vld_q[k] <= sb_vld_d[k];
        sb_rd_q[k]  <= sb_rd_d[k];
        sb_ld_q[k]  <= sb_ld_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed pipeline scenarios plus random traffic,
// checked against a queue-based model of the in-flight instructions.
module tb_pipe_hazard_unit;
  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int LRS  = 2;
  localparam int CW   = 2;
  localparam int SW   = 2;

  logic clk, rst;
  logic id_valid, re1, re2, we, ld, flush, hold;
  logic [4:0] a1, a2, rd;
  logic [XLEN-1:0] rf1, rf2, d1, d2;
  logic [NS*XLEN-1:0] sdata;
  logic stall;
  logic [SW-1:0] sel1, sel2;
  logic [CW-1:0] cnt;

  pipe_hazard_unit #(.XLEN(XLEN), .FWD_STAGES(NS), .LOAD_READY_STAGE(LRS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .rs1_re_i(re1), .rs2_re_i(re2),
    .rs1_addr_i(a1), .rs2_addr_i(a2), .rd_we_i(we), .rd_addr_i(rd), .is_load_i(ld),
    .flush_i(flush), .hold_i(hold), .rs1_reg_data_i(rf1), .rs2_reg_data_i(rf2),
    .stage_data_i(sdata), .stall_o(stall), .fwd_sel1_o(sel1), .fwd_sel2_o(sel2),
    .rs1_data_o(d1), .rs2_data_o(d2), .stall_cnt_o(cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue front = youngest in-flight instruction (EX), back = WB
  typedef struct { logic v; logic [4:0] rd; logic ld; } rec_t;
  rec_t sb[$];
  int   n_tests, n_fail, exp_cnt;
  logic [4:0] pool [4] = '{5'd0, 5'd5, 5'd6, 5'd9};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void resolve(input logic re, input logic [4:0] a, input logic [31:0] rf,
                                  output logic h, output logic [SW-1:0] s, output logic [31:0] d);
    bit found = 0;
    h = 0; s = 0; d = 0;
    if (re && a != 0) begin
      d = rf;
      for (int i = 0; i < sb.size(); i++) begin
        if (!found && sb[i].v && sb[i].rd == a) begin
          found = 1;
          if (sb[i].ld && (i + 1) < LRS) h = 1;
          else begin s = SW'(i + 1); d = sdata[i*XLEN +: XLEN]; end
        end
      end
    end
  endfunction

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < NS; i++) sb.push_back('{1'b0, 5'd0, 1'b0});
    exp_cnt = 0;
  endtask

  task automatic drive(input logic iv, input logic r1, input logic [4:0] x1, input logic r2,
                       input logic [4:0] x2, input logic w, input logic [4:0] rdst,
                       input logic isld, input logic fl, input logic hd);
    id_valid = iv; re1 = r1; a1 = x1; re2 = r2; a2 = x2; we = w; rd = rdst; ld = isld;
    flush = fl; hold = hd;
    rf1 = $urandom; rf2 = $urandom; sdata = {$urandom, $urandom, $urandom};
  endtask

  // Check all outputs against the model, then advance one clock
  task automatic cycle();
    logic h1, h2, es;
    logic [SW-1:0] s1, s2;
    logic [31:0] e1, e2;
    #2;
    resolve(re1, a1, rf1, h1, s1, e1);
    resolve(re2, a2, rf2, h2, s2, e2);
    es = (h1 | h2) & id_valid & ~flush;
    chk("stall", stall, es);
    chk("cnt", cnt, exp_cnt);
    if (!h1) begin chk("sel1", sel1, s1); chk("data1", d1, e1); end
    if (!h2) begin chk("sel2", sel2, s2); chk("data2", d2, e2); end
    @(posedge clk);
    if (!hold) begin
      if (es && exp_cnt < 3) exp_cnt++;
      sb.push_front((flush || es) ? '{1'b0, 5'd0, 1'b0}
                                  : '{id_valid && we && rd != 0, rd, ld});
      void'(sb.pop_back());
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_cnt", cnt, 0);
    cycle();

    // ALU RAW: addi x5, then add x6,x5,x5 forwarded through EX, MEM, WB
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); cycle();
    drive(1, 1, 5, 1, 5, 1, 6, 0, 0, 0); sdata[31:0] = 32'h7;
    #1 chk("raw_sel1", sel1, 1); chk("raw_sel2", sel2, 1); chk("raw_data", d1, 32'h7);
    cycle();
    drive(0, 1, 5, 1, 5, 0, 0, 0, 0, 0); #1 chk("raw_sel_mem", sel1, 2); cycle();
    drive(0, 1, 5, 1, 5, 0, 0, 0, 0, 0); #1 chk("raw_sel_wb", sel1, 3); cycle();
    drive(0, 1, 5, 1, 5, 0, 0, 0, 0, 0); #1 chk("raw_sel_rf", sel1, 0); cycle();

    // Load-use: lw x5, then add x7,x5,x1 stalls one cycle
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    drive(1, 1, 5, 1, 1, 1, 7, 0, 0, 0); #1 chk("lu_stall", stall, 1); cycle();
    drive(1, 1, 5, 1, 1, 1, 7, 0, 0, 0);
    #1 chk("lu_release", stall, 0); chk("lu_sel1", sel1, 2); chk("lu_sel2", sel2, 0);
    chk("lu_cnt", cnt, 1);
    cycle();

    // Hold for 3 cycles during a load-use, then exactly one more stall
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5, 0, 0, 1, 7, 0, 0, 1); #1 chk("hold_stall", stall, 1); cycle();
    end
    drive(1, 1, 5, 0, 0, 1, 7, 0, 0, 0); cycle();
    drive(1, 1, 5, 0, 0, 1, 7, 0, 0, 0); #1 chk("hold_after", stall, 0); cycle();

    // Flush beats a load-use hazard
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    drive(1, 1, 5, 1, 1, 1, 7, 0, 1, 0); #1 chk("fl_stall", stall, 0); cycle();

    // x0 never tracked; youngest of duplicate rd wins
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    drive(1, 1, 0, 0, 0, 1, 9, 0, 0, 0); #1 chk("x0_sel", sel1, 0); chk("x0_data", d1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); cycle();
    drive(1, 1, 9, 1, 9, 0, 0, 0, 0, 0); #1 chk("prio_sel", sel1, 1); cycle();

    // Saturation: four load-use stalls with a 2-bit counter
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
      drive(1, 1, 5, 0, 0, 1, 7, 0, 0, 0); cycle();
      drive(1, 1, 5, 0, 0, 1, 7, 0, 0, 0); cycle();
    end
    #1 chk("sat_cnt", cnt, 3);

    // Asynchronous reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    drive(1, 1, 5, 0, 0, 1, 7, 0, 0, 0);
    #1 chk("pre_rst_stall", stall, 1);
    rst = 1'b0;
    #1 chk("arst_stall", stall, 0); chk("arst_cnt", cnt, 0);
    chk("arst_sel", sel1, 0); chk("arst_data", d1, rf1);
    model_clear();
    @(posedge clk); #1 rst = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 5'($urandom) : pool[$urandom_range(0, 3)],
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 5'($urandom) : pool[$urandom_range(0, 3)],
            $urandom_range(0, 3) != 0, pool[$urandom_range(0, 3)],
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
